// File: rtl/host_link.sv
// Host-side end of the accelerator's external port: forwards upstream beats onto the
// shared con buses, captures chip outputs into a show-ahead FIFO and sequences a run.
module host_link #(
    parameter int unsigned IO_DATA_WIDTH      = 16,
    parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
    parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
    parameter int unsigned OUTPUT_NB_CHANNELS = 64,
    parameter int unsigned OUT_FIFO_DEPTH     = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_in,
    input  logic                                  go,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overflow,
    input  logic                                  up_valid,
    output logic                                  up_ready,
    input  logic [3*IO_DATA_WIDTH-1:0]            up_data,
    output logic                                  dn_valid,
    input  logic                                  dn_ready,
    output logic [3*IO_DATA_WIDTH-1:0]            dn_data,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  dn_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] dn_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] dn_ch,
    inout  wire  [IO_DATA_WIDTH-1:0]              con_1,
    inout  wire  [IO_DATA_WIDTH-1:0]              con_2,
    inout  wire  [IO_DATA_WIDTH-1:0]              con_3,
    output logic                                  con_valid,
    input  logic                                  con_ready,
    input  logic                                  driving_cons,
    input  logic                                  output_valid,
    input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
    input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
    input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
    output logic                                  start,
    input  logic                                  running
);
    localparam int unsigned W  = IO_DATA_WIDTH;
    localparam int unsigned XW = $clog2(FEATURE_MAP_WIDTH);
    localparam int unsigned YW = $clog2(FEATURE_MAP_HEIGHT);
    localparam int unsigned CW = $clog2(OUTPUT_NB_CHANNELS);
    localparam int unsigned EW = 3*W + XW + YW + CW;
    localparam int unsigned AW = $clog2(OUT_FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, WAIT_RUN, ACTIVE, DONE} state_t;

    state_t state, state_next;

    always_ff @(posedge clk) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (go) state_next = START;
            START:    state_next = WAIT_RUN;
            WAIT_RUN: if (running) state_next = ACTIVE;
            ACTIVE:   if (!running) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign start = (state == START);
    assign done  = (state == DONE);

    // own lags driving_cons by a cycle: release is immediate, reclaim waits one turnaround cycle
    logic           own;
    logic           drive;
    logic [3*W-1:0] hold;
    logic           hold_v;
    logic           transfer;
    logic           up_accept;

    always_ff @(posedge clk) begin
        if (rst_in) own <= 1'b0;
        else        own <= !driving_cons;
    end

    assign drive     = own & !driving_cons;
    assign con_1     = drive ? hold[W-1:0]     : 'z;
    assign con_2     = drive ? hold[2*W-1:W]   : 'z;
    assign con_3     = drive ? hold[3*W-1:2*W] : 'z;
    assign con_valid = hold_v & drive;
    assign transfer  = con_valid & con_ready;
    assign up_ready  = (state == ACTIVE) & (!hold_v | transfer);
    assign up_accept = up_valid & up_ready;

    always_ff @(posedge clk) begin
        if (rst_in)         hold_v <= 1'b0;
        else if (up_accept) hold_v <= 1'b1;
        else if (transfer)  hold_v <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (up_accept) hold <= up_data;
    end

    // Output FIFO: pointers carry an extra wrap bit to tell full from empty
    logic [EW-1:0] mem [OUT_FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop, push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push    = output_valid & driving_cons;
    assign pop     = dn_valid & dn_ready;
    assign push_ok = push & (!full | pop);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= {con_3, con_2, con_1, output_x, output_y, output_ch};
    end

    assign dn_valid = !empty;
    assign {dn_data, dn_x, dn_y, dn_ch} = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_host_link.sv
// Directed bench for host_link: run sequencing, streaming input, bus turnaround,
// output capture, FIFO overflow and mid-run reset.
module tb_host_link;
    logic        clk = 1'b0;
    logic        rst_in, go, up_valid, dn_ready, con_ready, driving_cons;
    logic        output_valid, running;
    logic [47:0] up_data;
    logic [9:0]  output_x, output_y;
    logic [5:0]  output_ch;
    logic        busy, done, overflow, up_ready, dn_valid, con_valid, start;
    logic [47:0] dn_data;
    logic [9:0]  dn_x, dn_y;
    logic [5:0]  dn_ch;
    wire  [15:0] con_1, con_2, con_3;

    logic        chip_drv;
    logic [15:0] chip_c1, chip_c2, chip_c3;

    assign con_1 = chip_drv ? chip_c1 : 'z;
    assign con_2 = chip_drv ? chip_c2 : 'z;
    assign con_3 = chip_drv ? chip_c3 : 'z;

    int n_tests = 0;
    int n_fail  = 0;

    host_link #(
        .IO_DATA_WIDTH(16), .FEATURE_MAP_WIDTH(1024), .FEATURE_MAP_HEIGHT(1024),
        .OUTPUT_NB_CHANNELS(64), .OUT_FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst_in(rst_in), .go(go), .busy(busy), .done(done), .overflow(overflow),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
        .dn_x(dn_x), .dn_y(dn_y), .dn_ch(dn_ch),
        .con_1(con_1), .con_2(con_2), .con_3(con_3),
        .con_valid(con_valid), .con_ready(con_ready), .driving_cons(driving_cons),
        .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
        .output_ch(output_ch), .start(start), .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int ui, ti;
    bit stalled;
    logic [15:0] stall_val;
    int drain_exp [8] = '{11, 12, 13, 14, 15, 16, 17, 19};

    initial begin
        rst_in = 1'b1; go = 1'b0; up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
        con_ready = 1'b0; driving_cons = 1'b0; output_valid = 1'b0; running = 1'b0;
        output_x = '0; output_y = '0; output_ch = '0;
        chip_drv = 1'b0; chip_c1 = '0; chip_c2 = '0; chip_c3 = '0;

        // Reset state; a probe value driven by the bench must read back untouched
        repeat (3) step();
        chip_drv = 1'b1; chip_c1 = 16'h5A5A;
        #1;
        check("rst_bus_released", con_1, 16'h5A5A);
        chip_drv = 1'b0;
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_con_valid", con_valid, 0);
        check("rst_up_ready", up_ready, 0);
        check("rst_dn_valid", dn_valid, 0);
        rst_in = 1'b0;
        step();

        // Run sequencing
        go = 1'b1;
        step();
        go = 1'b0;
        #1;
        check("start_pulse", start, 1);
        check("busy_start", busy, 1);
        step();
        check("start_one_cycle", start, 0);
        check("busy_wait_run", busy, 1);
        check("up_ready_wait_run", up_ready, 0);
        running = 1'b1;
        step();
        check("up_ready_active", up_ready, 1);

        // Streaming input: six beats, chip accepts every other cycle
        ui = 0; ti = 0; stalled = 0; stall_val = '0;
        for (int cyc = 0; cyc < 40 && ti < 6; cyc++) begin
            up_valid  = (ui < 6);
            up_data   = {16'(16'h0200 + ui), 16'(16'h0100 + ui), 16'(ui + 1)};
            con_ready = cyc[0];
            #1;
            check("busy_running", busy, 1);
            if (stalled && con_valid) check("hold_stable", con_1, stall_val);
            stalled = 0;
            if (con_valid && con_ready) begin
                check("xfer_con_1", con_1, 16'(ti + 1));
                check("xfer_con_2", con_2, 16'(16'h0100 + ti));
                check("xfer_con_3", con_3, 16'(16'h0200 + ti));
                ti++;
            end else if (con_valid) begin
                stalled   = 1;
                stall_val = con_1;
            end
            if (up_valid && up_ready) ui++;
            step();
        end
        up_valid = 1'b0; con_ready = 1'b0;
        check("xfer_count", ti, 6);

        // Bus contention with an unaccepted beat
        up_valid = 1'b1; up_data = {16'h0079, 16'h0078, 16'h0077};
        #1;
        check("cont_up_ready", up_ready, 1);
        step();
        up_valid = 1'b0;
        #1;
        check("in_latency_valid", con_valid, 1);
        check("in_latency_data", con_1, 16'h0077);
        driving_cons = 1'b1; chip_drv = 1'b1; chip_c1 = 16'hC0C0;
        #1;
        check("cont_release_valid", con_valid, 0);
        check("cont_release_bus", con_1, 16'hC0C0);
        check("cont_up_ready_held", up_ready, 0);
        step();
        check("cont_chip_owns", con_valid, 0);
        driving_cons = 1'b0; con_ready = 1'b1;
        #1;
        check("turnaround_valid", con_valid, 0);
        check("turnaround_bus", con_1, 16'hC0C0);
        step();
        chip_drv = 1'b0;
        #1;
        check("reclaim_valid", con_valid, 1);
        check("reclaim_data", con_1, 16'h0077);
        step();
        con_ready = 1'b0;
        #1;
        check("beat_once", con_valid, 0);
        check("beat_once_ready", up_ready, 1);

        // Output capture with downstream always ready
        driving_cons = 1'b1; chip_drv = 1'b1;
        chip_c1 = 16'hA5A5; chip_c2 = 16'h5A5A; chip_c3 = 16'h0F0F;
        output_y = 10'd5; output_ch = 6'd63; dn_ready = 1'b1;
        #1;
        check("cap_empty", dn_valid, 0);
        for (int k = 1; k <= 4; k++) begin
            output_valid = 1'b1; output_x = 10'(k);
            step();
            check("cap_valid", dn_valid, 1);
            check("cap_x", dn_x, k);
            check("cap_ch", dn_ch, 63);
            check("cap_data", dn_data, 48'h0F0F_5A5A_A5A5);
        end
        output_valid = 1'b0;
        step();
        check("cap_drained", dn_valid, 0);

        // FIFO full and overflow
        dn_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            output_valid = 1'b1; output_x = 10'(10 + k);
            step();
            if (k == 7) check("full_no_overflow", overflow, 0);
            if (k == 8) check("overflow_set", overflow, 1);
        end
        output_x = 10'd19; dn_ready = 1'b1;
        #1;
        check("full_head", dn_x, 10);
        step();
        output_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("drain_valid", dn_valid, 1);
            check("drain_x", dn_x, drain_exp[k]);
            step();
        end
        check("drain_empty", dn_valid, 0);
        check("overflow_sticky", overflow, 1);
        dn_ready = 1'b0;

        // Run end
        driving_cons = 1'b0; chip_drv = 1'b0; running = 1'b0;
        step();
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        step();
        check("done_one_cycle", done, 0);
        check("busy_cleared", busy, 0);

        // Reset mid-run with a held beat and three FIFO entries
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        running = 1'b1;
        step();
        driving_cons = 1'b1; chip_drv = 1'b1;
        up_valid = 1'b1; up_data = {16'h00C5, 16'h00C4, 16'h00C3};
        output_valid = 1'b1;
        #1;
        check("mr_up_ready", up_ready, 1);
        step();
        up_valid = 1'b0;
        step();
        step();
        output_valid = 1'b0; driving_cons = 1'b0; chip_drv = 1'b0;
        step();
        check("mr_con_valid", con_valid, 1);
        check("mr_dn_valid", dn_valid, 1);
        rst_in = 1'b1;
        step();
        check("mr_busy", busy, 0);
        check("mr_con_valid_clr", con_valid, 0);
        check("mr_dn_valid_clr", dn_valid, 0);
        check("mr_overflow_clr", overflow, 0);
        check("mr_up_ready_clr", up_ready, 0);
        chip_drv = 1'b1; chip_c1 = 16'h3C3C;
        #1;
        check("mr_bus_released", con_1, 16'h3C3C);
        chip_drv = 1'b0; rst_in = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
